// File: rtl/sync_fifo_pkg.sv
// Shared defaults and derived widths for the synchronous FIFO.
// Optional error flags are enabled by defining SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage for sync_fifo: synchronous write, addressed read, no reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The owner registers this value into dout, so a same-edge write never leaks through.
  assign rdata = mem_q[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and full/empty flags from the count.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs d_ovf/d_udf.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] din,
  output logic             d_full,
  output logic             d_empty,
  output logic [WIDTH-1:0] dout
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic             d_ovf,
  output logic             d_udf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             rd_acc;
  logic             wr_acc;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // A read frees a slot this cycle, so a write into a full FIFO is still taken.
  always_comb begin
    rd_acc   = re && (cnt_q != '0);
    wr_acc   = we && ((cnt_q != CNT_W'(DEPTH)) || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    dout_d   = rd_acc ? mem_rdata : dout_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign d_full  = (cnt_q == CNT_W'(DEPTH));
  assign d_empty = (cnt_q == '0);
  assign dout    = dout_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q || (we && !wr_acc);
    udf_d = udf_q || (re && !rd_acc);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign d_ovf = ovf_q;
  assign d_udf = udf_q;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
// Also checks d_ovf/d_udf when built with SYNC_FIFO_ERR_EN.
module tb_sync_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk  = 1'b0;
  logic         nrst = 1'b0;
  logic         we   = 1'b0;
  logic         re   = 1'b0;
  logic [W-1:0] din  = '0;
  logic         d_full;
  logic         d_empty;
  logic [W-1:0] dout;
`ifdef SYNC_FIFO_ERR_EN
  logic         d_ovf;
  logic         d_udf;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus the last value read out.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  bit           m_ovf  = 1'b0;
  bit           m_udf  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .we      (we),
    .re      (re),
    .din     (din),
    .d_full  (d_full),
    .d_empty (d_empty),
    .dout    (dout)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .d_ovf   (d_ovf),
    .d_udf   (d_udf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".dout"},  32'(dout),    32'(m_dout));
    chk({tag, ".full"},  32'(d_full),  32'(q.size() == D));
    chk({tag, ".empty"}, 32'(d_empty), 32'(q.size() == 0));
`ifdef SYNC_FIFO_ERR_EN
    chk({tag, ".ovf"},   32'(d_ovf),   32'(m_ovf));
    chk({tag, ".udf"},   32'(d_udf),   32'(m_udf));
`endif
  endtask

  // One clock cycle: drive on the falling edge, advance the model, check after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    we  = w;
    re  = r;
    din = d;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < D) || rd_ok);
    if (r && !rd_ok) m_udf = 1'b1;
    if (w && !wr_ok) m_ovf = 1'b1;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    @(posedge clk);
    #1;
    check_outs(tag);
    $display("cycle %s we=%0b re=%0b din=%0h dout=%0h full=%0b empty=%0b",
             tag, w, r, d, dout, d_full, d_empty);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (q.size() > 0 && guard < 4 * D) begin
      cyc(1'b0, 1'b1, W'($urandom), tag);
      guard++;
    end
  endtask

  initial begin
    // Reset is asynchronous: outputs must be at reset values before any clock edge.
    #2;
    check_outs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_held");
    @(negedge clk);
    nrst = 1'b1;

    cyc(1'b0, 1'b1, 8'h5A, "rd_empty");
    cyc(1'b1, 1'b1, 8'h33, "wr_rd_empty");
    cyc(1'b0, 1'b1, 8'h00, "rd_one");
    cyc(1'b0, 1'b1, 8'h00, "rd_empty2");

    for (int i = 1; i <= D; i++) cyc(1'b1, 1'b0, W'(i), "fill");
    cyc(1'b1, 1'b0, 8'd9, "wr_full_drop");

    for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 8'h00, "drain");
    cyc(1'b0, 1'b1, 8'h00, "drain_extra");

    // Continuous writes with interleaved reads, wrapping both pointers.
    for (int i = 1; i <= 20; i++) cyc(1'b1, (i % 3) != 1, W'(i), "stream");
    drain("stream_drain");

    for (int i = 1; i <= D; i++) cyc(1'b1, 1'b0, W'(i), "fill2");
    cyc(1'b1, 1'b1, 8'd9, "full_wr_rd");
    drain("full_drain");

    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), W'($urandom), "random");
    end
    drain("random_drain");

    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, W'(8'h10 + i), "pre_rst");
    @(negedge clk);
    nrst = 1'b0;
    we   = 1'b1;
    re   = 1'b1;
    din  = 8'h77;
    model_reset();
    #1;
    check_outs("mid_rst_async");
    @(posedge clk);
    #1;
    check_outs("mid_rst_held");
    @(negedge clk);
    nrst = 1'b1;
    we   = 1'b0;
    re   = 1'b0;

    cyc(1'b1, 1'b0, 8'hAA, "post_rst_wr");
    cyc(1'b0, 1'b1, 8'h00, "post_rst_rd");
    cyc(1'b0, 1'b1, 8'h00, "post_rst_rd_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, data bit width; DEPTH, 8, entry count (power of two, >=2).
REQ-002 Ports SHALL be, in order:
  clk  input  1  single clock, all state updates on rising edge
  nrst  input  1  asynchronous, active-low reset
  we  input  1  write request
  re  input  1  read request
  din  input  WIDTH  write data
  d_full  output  1  FIFO holds DEPTH entries
  d_empty  output  1  FIFO holds 0 entries
  dout  output  WIDTH  read data, registered
REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-low reset (nrst); no other clocks or resets.

Function
REQ-004 Occupancy count SHALL range 0..DEPTH, held in a $clog2(DEPTH)+1-bit counter; read/write pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-005 A write SHALL be accepted at a rising clk edge when we=1 and (d_full=0 or an accepted read occurs in the same cycle); din is stored at the write pointer, and the pointer increments.
REQ-006 A read SHALL be accepted at a rising clk edge when re=1 and d_empty=0; the entry at the read pointer is loaded into dout at that edge (1-cycle latency), and the pointer increments.
REQ-007 dout SHALL hold its last value in cycles with no accepted read.
REQ-008 A write while full with no accepted read SHALL be dropped; stored data and pointers are unchanged.
REQ-009 A read while empty SHALL be ignored; dout holds; no fall-through of same-cycle din.
REQ-010 Simultaneous accepted read and write SHALL leave the count unchanged; when full, both are accepted; when empty, only the write is accepted.
REQ-011 d_full SHALL equal (count==DEPTH), and d_empty SHALL equal (count==0); both SHALL be driven from registered state only, with no combinational path from we/re/din.
REQ-012 Data SHALL be read out in strict write order across pointer wrap-around.

Reset
REQ-013 With nrst=0, the pointers, count and dout SHALL clear to 0, d_empty SHALL be 1 and d_full SHALL be 0, immediately and independent of clk.
REQ-014 Reset asserted mid-operation SHALL discard all contents; storage array contents need not be cleared.
REQ-015 we/re SHALL have no effect while nrst=0; normal operation resumes at the first rising clk edge after deassertion.

Configuration
REQ-016 Macro SYNC_FIFO_ERR_EN SHALL, when defined, add output ports d_ovf (1) and d_udf (1) after dout.
REQ-017 With SYNC_FIFO_ERR_EN, d_ovf SHALL set on a dropped write and d_udf SHALL set on an ignored read; both are sticky until reset, and both reset to 0.
REQ-018 Without SYNC_FIFO_ERR_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-019 Package sync_fifo_pkg SHALL hold the WIDTH/DEPTH default constants and the pointer/count width localparams.
REQ-020 Sub-module sync_fifo_mem SHALL implement the DEPTH x WIDTH storage array (synchronous write, addressed read, no reset); sync_fifo SHALL hold the pointers, count, flags and dout register.

Verification
REQ-021 Reset: nrst=0 then release -> d_empty=1, d_full=0, dout=0; re=1 while empty -> dout stays 0.
REQ-022 Fill: write 1..8 with re=0 -> d_full=1 after the 8th edge; write 9 -> dropped (d_ovf=1 if enabled).
REQ-023 Drain: re=1 for 8 cycles after the fill -> dout=1,2,...,8 one per edge; d_empty=1 after the last read; a 9th read -> dout holds 8.
REQ-024 Concurrent streaming: we=1 with din=1..20 and re=1 interleaved over 13 cycles -> every accepted value emerges in order across pointer wrap; count never exceeds 8.
REQ-025 Full with simultaneous we/re: full FIFO holding 1..8, din=9 -> dout=1, d_full stays 1; a later drain yields 2..9.
REQ-026 Mid-operation reset: nrst=0 with 5 entries held -> d_empty=1 immediately; a subsequent write of 0xAA then read -> dout=0xAA.
